// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged with all-ones quotient.
module seq_divider #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam int unsigned PR_W  = DIVISOR_W + 1;

  // ZERO is a one-cycle, non-busy hop that gives divide-by-zero its fixed latency
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_last;

  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W-1:0]  r_pr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_busy;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;

  logic [PR_W-1:0]       w_pr_shift;
  logic [PR_W-1:0]       w_diff;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_pr_new;
  logic [DIVIDEND_W-1:0] w_dvd_new;

  // One restoring step. r_pr < r_dvs always, so w_pr_shift < 2*r_dvs and the
  // top bit of w_diff is a clean borrow (set exactly when w_pr_shift < r_dvs).
  always_comb begin
    w_pr_shift = {r_pr, r_dvd[DIVIDEND_W-1]};
    w_diff     = w_pr_shift - {1'b0, r_dvs};
    w_ge       = ~w_diff[PR_W-1];
    w_pr_new   = w_ge ? w_diff[DIVISOR_W-1:0] : w_pr_shift[DIVISOR_W-1:0];
    w_dvd_new  = {r_dvd[DIVIDEND_W-2:0], w_ge};
    w_last     = (r_count == CNT_W'(DIVIDEND_W - 1));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (divisor == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_ZERO:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; dividend register doubles as quotient shifter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_pr        <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_dvd   <= dividend;
        r_dvs   <= divisor;
        r_pr    <= '0;
        r_count <= '0;
        r_dbz   <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_dvd   <= w_dvd_new;
        r_pr    <= w_pr_new;
        r_count <= r_count + CNT_W'(1);
        if (w_last) begin
          r_quotient  <= w_dvd_new;
          r_remainder <= w_pr_new;
        end
      end else if (r_state == S_ZERO) begin
        r_quotient  <= '1;
        r_remainder <= '0;
        r_dbz       <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios with literal results
// plus randomized traffic compared every cycle against an arithmetic timeline model.
module tb_seq_divider;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act_v, exp_v);
    end
  endtask

  // Timeline model: an accepted op finishes at a known edge index with a/b, a%b
  int         k = 0;
  int         done_edge = 0;
  bit         act = 1'b0;
  logic [7:0] mq = '0, pq = '0;
  logic [3:0] mr = '0, pr_m = '0;
  logic       mdbz = 1'b0, pdbz = 1'b0;

  always @(posedge clock) begin
    k++;
    if (reset) begin
      act  = 1'b0;
      mq   = '0;
      mr   = '0;
      mdbz = 1'b0;
    end else begin
      if (act && k == done_edge) begin
        mq   = pq;
        mr   = pr_m;
        mdbz = pdbz;
      end
      if ((!act || k > done_edge + 1) && start) begin
        act  = 1'b1;
        mdbz = 1'b0;
        if (divisor == 4'd0) begin
          pq = 8'hFF; pr_m = 4'd0; pdbz = 1'b1; done_edge = k + 1;
        end else begin
          pq = 8'(int'(dividend) / int'(divisor));
          pr_m = 4'(int'(dividend) % int'(divisor));
          pdbz = 1'b0;
          done_edge = k + 8;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (k > 0) begin
      chk("busy",        32'(busy),        32'(act && !pdbz && k < done_edge));
      chk("done",        32'(done),        32'(act && k == done_edge));
      chk("quotient",    32'(quotient),    32'(mq));
      chk("remainder",   32'(remainder),   32'(mr));
      chk("div_by_zero", 32'(div_by_zero), 32'(mdbz));
    end
  end

  // Waits (bounded) for done; n = cycles after the accept edge, bc = busy cycles seen
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    @(negedge clock);
    while (!done && n < 30) begin
      if (busy) bc++;
      n++;
      @(negedge clock);
    end
    chk("done_timeout", 32'(n < 30), 32'd1);
  endtask

  task automatic op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                    input logic [3:0] er, input logic edbz, input int elat, input int ebusy);
    int n, bc;
    @(posedge clock); #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock); #2;
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    wait_done(n, bc);
    chk("latency",   32'(n),           32'(elat));
    chk("busy_cyc",  32'(bc),          32'(ebusy));
    chk("lit_q",     32'(quotient),    32'(eq));
    chk("lit_r",     32'(remainder),   32'(er));
    chk("lit_dbz",   32'(div_by_zero), 32'(edbz));
    @(posedge clock);
  endtask

  initial begin
    int n, bc;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(quotient), 32'd0);
    chk("rst_r",    32'(remainder), 32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);

    op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8, 8);
    op(8'd255, 4'd1,  8'hFF,  4'd0, 1'b0, 8, 8);
    op(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8, 8);
    op(8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 8, 8);
    op(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8, 8);
    op(8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 1, 0);

    // start pulsed with new operands during RUN is ignored
    @(posedge clock); #2 start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clock); #2 start = 1'b0;
    repeat (2) @(posedge clock);
    #2 start = 1'b1; dividend = 8'd99; divisor = 4'd10;
    @(posedge clock); #2 start = 1'b0;
    wait_done(n, bc);
    chk("ign_q", 32'(quotient), 32'd28);
    chk("ign_r", 32'(remainder), 32'd4);
    repeat (3) @(posedge clock);

    // reset in the middle of RUN aborts without a done pulse
    #2 start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clock); #2 start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q",    32'(quotient), 32'd0);
    chk("abort_r",    32'(remainder), 32'd0);
    chk("abort_dbz",  32'(div_by_zero), 32'd0);
    repeat (12) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    op(8'd99, 4'd10, 8'd9, 4'd9, 1'b0, 8, 8);

    // start held high across two ops
    @(posedge clock); #2 start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clock); #2 dividend = 8'd99; divisor = 4'd10;
    wait_done(n, bc);
    chk("held1_q", 32'(quotient), 32'd28);
    chk("held1_r", 32'(remainder), 32'd4);
    @(negedge clock);
    chk("held_hold_q", 32'(quotient), 32'd28);
    chk("held_hold_r", 32'(remainder), 32'd4);
    @(posedge clock); #2 start = 1'b0;
    wait_done(n, bc);
    chk("held2_lat", 32'(n), 32'd8);
    chk("held2_q", 32'(quotient), 32'd9);
    chk("held2_r", 32'(remainder), 32'd9);
    repeat (2) @(posedge clock);

    // randomized traffic: starts at any time, occasional zero divisor and reset
    repeat (800) begin
      @(posedge clock); #2;
      reset    = ($urandom_range(0, 79) == 0);
      start    = ($urandom_range(0, 2) == 0);
      dividend = 8'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    end
    #0 reset = 1'b0; start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
